// File: rtl/coder_pkg.sv
// coder_pkg: shared sizes and state encoding for code-block segmentation
package coder_pkg;
  localparam int SIZE_W = 16;
  localparam int CNT_W = 13;
  localparam logic [CNT_W-1:0] K_LARGE = 13'd6144;
  localparam logic [CNT_W-1:0] K_SMALL = 13'd1056;
  typedef enum logic [1:0] {IDLE, SIZE, DATA, FILL} state_t;
endpackage

// File: rtl/cb_segment_ctrl_if.sv
// cb_segment_ctrl_if: TB input, size strobe and encoder-side handshake bundle
interface cb_segment_ctrl_if;
  logic [coder_pkg::SIZE_W-1:0] tb_size_in;
  logic wreq_size, tb_in, wreq_data, data_ready, busy, enc_ready;
  logic cb_bit, cb_valid, cb_start, cb_size_sel, cb_last;
  modport master (
    output tb_size_in, wreq_size, tb_in, wreq_data, enc_ready,
    input data_ready, busy, cb_bit, cb_valid, cb_start, cb_size_sel, cb_last
  );
  modport slave (
    input tb_size_in, wreq_size, tb_in, wreq_data, enc_ready,
    output data_ready, busy, cb_bit, cb_valid, cb_start, cb_size_sel, cb_last
  );
endinterface

// File: rtl/cb_size_calc.sv
// cb_size_calc: picks block size, data bit count and trailing filler for the next block
module cb_size_calc
  import coder_pkg::*;
(
  input  logic [SIZE_W-1:0] remaining,
  output logic              size_sel,
  output logic [CNT_W-1:0]  data_bits,
  output logic [CNT_W-1:0]  fill
);
  logic lg, sm;
  always_comb begin
    lg = remaining >= SIZE_W'(K_LARGE);
    sm = remaining <= SIZE_W'(K_SMALL);
    size_sel = !sm;
    data_bits = lg ? K_LARGE : remaining[CNT_W-1:0];
    fill = lg ? '0 : (sm ? K_SMALL : K_LARGE) - remaining[CNT_W-1:0];
  end
endmodule

// File: rtl/cb_segment_ctrl.sv
// cb_segment_ctrl: splits a serial TB into K=6144/1056 code blocks with trailing zero filler
module cb_segment_ctrl
  import coder_pkg::*;
(
  input logic clk,
  input logic reset,
  cb_segment_ctrl_if.slave bus
);
  state_t state, state_nx;
  logic [SIZE_W-1:0] remaining;
  logic [CNT_W-1:0] bit_cnt, cnt_nx, fill, k, calc_data, calc_fill;
  logic sel, calc_sel, load, xfer, data_done, blk_done;
  cb_size_calc u_calc (
    .remaining(remaining),
    .size_sel(calc_sel),
    .data_bits(calc_data),
    .fill(calc_fill)
  );
  always_comb begin
    k = sel ? K_LARGE : K_SMALL;
    cnt_nx = bit_cnt + CNT_W'(1);
    load = state == IDLE && bus.wreq_size && |bus.tb_size_in;
    xfer = state == DATA ? bus.wreq_data && bus.enc_ready : state == FILL && bus.enc_ready;
    data_done = cnt_nx == k - fill;
    blk_done = state == DATA ? data_done && fill == '0 : state == FILL && cnt_nx == k;
    state_nx = state;
    case (state)
      IDLE: state_nx = load ? SIZE : IDLE;
      SIZE: state_nx = DATA;
      DATA: if (xfer && data_done) state_nx = fill != '0 ? FILL : (|remaining ? SIZE : IDLE);
      FILL: if (xfer && blk_done) state_nx = |remaining ? SIZE : IDLE;
      default: state_nx = IDLE;
    endcase
    bus.busy = state != IDLE;
    bus.data_ready = state == DATA && bus.enc_ready;
    bus.cb_valid = xfer;
    bus.cb_bit = state == DATA && xfer && bus.tb_in;
    bus.cb_start = state == DATA && xfer && bit_cnt == '0;
    bus.cb_size_sel = sel;
    bus.cb_last = xfer && blk_done && remaining == '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // remaining is already net of the current block, so zero here marks the final block
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining <= '0;
      bit_cnt <= '0;
      sel <= 1'b0;
      fill <= '0;
    end else if (load) begin
      remaining <= bus.tb_size_in;
    end else if (state == SIZE) begin
      sel <= calc_sel;
      fill <= calc_fill;
      remaining <= remaining - SIZE_W'(calc_data);
      bit_cnt <= '0;
    end else if (xfer) begin
      bit_cnt <= cnt_nx;
    end
  end
endmodule

// File: tb/tb_cb_segment_ctrl.sv
// tb_cb_segment_ctrl: randomized stimulus checked against a block-list model of the output stream
module tb_cb_segment_ctrl;
  typedef struct packed {logic b; logic s; logic sel; logic l;} exp_t;
  logic clk = 0, reset = 1;
  int checks = 0, errors = 0, last_cyc = 0;
  exp_t exp_q[$];
  cb_segment_ctrl_if bus();
  cb_segment_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0d want %0d", n, a, e);
    end
  endtask
  function automatic void build(input int size, input bit bits[$]);
    int rem = size, pos = 0, kk, d;
    exp_q.delete();
    while (rem > 0) begin
      kk = rem > 1056 ? 6144 : 1056;
      d = rem >= 6144 ? 6144 : rem;
      for (int i = 0; i < kk; i++)
        exp_q.push_back('{b: i < d ? bits[pos+i] : 1'b0, s: i == 0, sel: kk == 6144,
                          l: rem == d && i == kk - 1});
      pos += d;
      rem -= d;
    end
  endfunction
  task automatic chk_zero(input string n);
    chk({n, "_busy"}, bus.busy, 0);
    chk({n, "_ready"}, bus.data_ready, 0);
    chk({n, "_valid"}, bus.cb_valid, 0);
    chk({n, "_bit"}, bus.cb_bit, 0);
    chk({n, "_start"}, bus.cb_start, 0);
    chk({n, "_sel"}, bus.cb_size_sel, 0);
    chk({n, "_last"}, bus.cb_last, 0);
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.cb_valid) begin
        chk("valid_without_enc", bus.enc_ready, 1);
        if (exp_q.size() == 0) chk("extra_output", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("cb_bit", bus.cb_bit, e.b);
          chk("cb_start", bus.cb_start, e.s);
          chk("cb_size_sel", bus.cb_size_sel, e.sel);
          chk("cb_last", bus.cb_last, e.l);
        end
      end
      if (!bus.enc_ready) chk("ready_gated", bus.data_ready, 0);
    end
  end
  task automatic run_tb(input int size, input int mode, input bit pulses, input int abort_at);
    bit bits[$];
    int idx = 0, cyc = 0;
    bit ph = 0;
    for (int i = 0; i < size; i++) bits.push_back(1'($urandom_range(0, 1)));
    build(size, bits);
    @(posedge clk); #1;
    bus.tb_size_in = 16'(size);
    bus.wreq_size = 1;
    @(posedge clk); #1;
    bus.wreq_size = 0;
    while ((exp_q.size() != 0 || bus.busy) && cyc < 40000) begin
      ph = ~ph;
      bus.enc_ready = mode == 0 ? 1'b1 : mode == 1 ? ph : ($urandom_range(0, 3) != 0);
      bus.wreq_data = mode == 2 ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.tb_in = idx < size ? bits[idx] : 1'($urandom_range(0, 1));
      bus.wreq_size = pulses && $urandom_range(0, 15) == 0;
      bus.tb_size_in = 16'($urandom_range(1, 20000));
      if (abort_at >= 0 && idx == abort_at) begin
        reset = 1;
        #1;
        chk_zero("mid_reset");
        exp_q.delete();
        @(posedge clk); #1;
        reset = 0;
        bus.wreq_size = 0;
        return;
      end
      @(negedge clk);
      if (bus.data_ready && bus.wreq_data) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    bus.wreq_size = 0;
    last_cyc = cyc;
    chk("no_timeout", int'(cyc < 40000), 1);
    chk("queue_drained", exp_q.size(), 0);
    chk("bits_consumed", idx, size);
    chk("idle_after", bus.busy, 0);
  endtask
  initial begin
    bit pin_bits[$];
    bus.tb_size_in = 0;
    bus.wreq_size = 0;
    bus.tb_in = 0;
    bus.wreq_data = 0;
    bus.enc_ready = 0;
    #1;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    for (int i = 0; i < 7010; i++) pin_bits.push_back(1'b1);
    build(7010, pin_bits);
    chk("pin_len", exp_q.size(), 7200);
    chk("pin_blk1_start", exp_q[6144].s, 1);
    chk("pin_blk1_sel", exp_q[6144].sel, 0);
    chk("pin_blk0_sel", exp_q[0].sel, 1);
    chk("pin_last_data", exp_q[7009].b, 1);
    chk("pin_first_fill", exp_q[7010].b, 0);
    chk("pin_last", exp_q[7199].l, 1);
    chk("pin_not_last", exp_q[6143].l, 0);
    exp_q.delete();
    run_tb(7010, 0, 0, -1);
    chk("cycles_7010", last_cyc, 7202);
    run_tb(6144, 0, 0, -1);
    chk("cycles_6144", last_cyc, 6145);
    run_tb(2000, 0, 0, -1);
    run_tb(1056, 0, 0, -1);
    chk("cycles_1056", last_cyc, 1057);
    run_tb(12288, 1, 0, -1);
    @(posedge clk); #1;
    bus.tb_size_in = 0;
    bus.wreq_size = 1;
    @(posedge clk); #1;
    bus.wreq_size = 0;
    @(negedge clk);
    chk("size0_ignored", bus.busy, 0);
    run_tb(800, 2, 1, -1);
    run_tb(7010, 2, 1, -1);
    run_tb(7010, 0, 0, 3000);
    run_tb(1056, 0, 0, -1);
    chk("cycles_after_reset", last_cyc, 1057);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
